// File: rtl/four_bank_drain_if.sv
// Bank-side and stream-side signals of the four-bank in-order drain.
interface four_bank_drain_if #(
  parameter int unsigned DW = 8
);
  logic [3:0]      bank_empty;
  logic [4*DW-1:0] bank_data;
  logic [3:0]      bank_rd;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    input  bank_empty, bank_data, out_ready,
    output bank_rd, out_data, out_valid
  );

  modport slave (
    output bank_empty, bank_data, out_ready,
    input  bank_rd, out_data, out_valid
  );
endinterface

// File: rtl/four_bank_drain.sv
// Pops four round-robin banks in rotation, restores byte order, and streams the bytes
// through a 2-entry skid buffer; a stall watchdog skips a bank that stays empty.
module four_bank_drain #(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  four_bank_drain_if.master     bus,
  output logic [1:0]            rd_ptr,
  output logic                  order_err,
  output logic [7:0]            skip_cnt,
  output logic [CW-1:0]         beat_cnt
);

  localparam int unsigned SCW = 8;

  typedef enum logic {RUN, SKIP} state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] stall_q;
  logic [1:0]     cnt_q, cnt_d;
  logic [DW-1:0]  tail_q;
  logic [DW-1:0]  head_in;
  logic [3:0]     others_empty;
  logic           pop, xfer, stall, stall_done;

  assign xfer       = bus.out_valid & bus.out_ready;
  assign head_in    = bus.bank_data[DW*32'(rd_ptr) +: DW];
  assign stall_done = stall && (stall_q == SCW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall_done) state_d = SKIP;
      SKIP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Pop strobe and stall detection; a stall needs every other bank to hold data
  always_comb begin
    pop          = 1'b0;
    stall        = 1'b0;
    bus.bank_rd  = '0;
    others_empty = bus.bank_empty;
    others_empty[rd_ptr] = 1'b0;
    if (!rst && state_q == RUN) begin
      pop   = !bus.bank_empty[rd_ptr] && (cnt_q < 2'd2);
      stall = bus.bank_empty[rd_ptr] && (others_empty == 4'd0) && (cnt_q < 2'd2);
    end
    bus.bank_rd[rd_ptr] = pop;
  end

  assign cnt_d = cnt_q + 2'(pop) - 2'(xfer);

  // Skid buffer: out_data is the head register, tail_q the second entry
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      tail_q        <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (pop) begin
        if (cnt_q == 2'd0 || xfer) bus.out_data <= head_in;
        else                       tail_q       <= head_in;
      end else if (xfer && cnt_q == 2'd2) begin
        bus.out_data <= tail_q;
      end
      cnt_q         <= cnt_d;
      bus.out_valid <= (cnt_d != 2'd0);
    end
  end

  // Pointer, watchdog and status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      stall_q   <= '0;
      order_err <= 1'b0;
      skip_cnt  <= '0;
      beat_cnt  <= '0;
    end else begin
      rd_ptr   <= rd_ptr + 2'(pop || (state_q == SKIP));
      beat_cnt <= beat_cnt + CW'(xfer);
      if (state_q == SKIP || !stall || stall_done) stall_q <= '0;
      else                                         stall_q <= stall_q + SCW'(1);
      if (state_q == SKIP) begin
        order_err <= 1'b1;
        if (skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_four_bank_drain.sv
// Directed bench for four_bank_drain: bank queues feed the DUT, a scoreboard checks the output stream.
module tb_four_bank_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_ptr;
  logic        order_err;
  logic [7:0]  skip_cnt;
  logic [15:0] beat_cnt;

  four_bank_drain_if #(.DW(8)) bus ();

  four_bank_drain #(.DW(8), .TIMEOUT(16), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rd_ptr    (rd_ptr),
    .order_err (order_err),
    .skip_cnt  (skip_cnt),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] bq [4][$];
  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int beats = 0;
  int tick_no, first_rd, first_v, xfer_first, xfer_last, xfer_n, npop;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_d = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_trk();
    tick_no = 0; first_rd = -1; first_v = -1;
    xfer_first = -1; xfer_last = -1; xfer_n = 0; npop = 0;
  endtask

  task automatic drive_banks();
    for (int i = 0; i < 4; i++) begin
      bus.bank_empty[i]       = (bq[i].size() == 0);
      bus.bank_data[8*i +: 8] = (bq[i].size() != 0) ? bq[i][0] : 8'h00;
    end
  endtask

  // One clock: drive banks, observe strobes at negedge, score the edge's effects after it
  task automatic tick();
    logic [3:0] s_rd;
    logic       s_v, s_r, ok;
    logic [7:0] s_d, e;
    drive_banks();
    @(negedge clk);
    s_rd = bus.bank_rd; s_v = bus.out_valid; s_r = bus.out_ready; s_d = bus.out_data;
    if (rst) chk("rd_in_rst", 32'(s_rd), 32'd0);
    else if (s_rd != 4'd0) begin
      ok = $onehot(s_rd);
      for (int i = 0; i < 4; i++) if (s_rd[i] && bq[i].size() == 0) ok = 1'b0;
      chk("rd_legal", 32'(ok), 32'd1);
      npop++;
      if (first_rd < 0) first_rd = tick_no;
    end
    if (prev_hold) chk("hold_data", 32'(s_d), 32'(prev_d));
    prev_hold = s_v && !s_r && !rst;
    prev_d    = s_d;
    if (s_v && first_v < 0) first_v = tick_no;
    @(posedge clk); #1;
    if (rst) begin
      exp_q.delete();
      beats = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (s_rd[i] && bq[i].size() != 0) void'(bq[i].pop_front());
      if (s_v && s_r) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(s_d), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(s_d), 32'(e));
        end
        beats++;
        if (xfer_first < 0) xfer_first = tick_no;
        xfer_last = tick_no;
        xfer_n++;
      end
    end
    chk("beat_cnt", 32'(beat_cnt), 32'(beats & 16'hFFFF));
    tick_no++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive_banks();
    clr_trk();
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data), 32'd0);
    chk("rst_ptr",   32'(rd_ptr), 32'd0);
    chk("rst_err",   32'(order_err), 32'd0);
    chk("rst_skip",  32'(skip_cnt), 32'd0);

    // In-order drain of two preloaded rounds
    clr_trk();
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) begin
        bq[b].push_back(8'((b + 1) * 16 + r));
        exp_q.push_back(8'((b + 1) * 16 + r));
      end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("t1_first_rd",  32'(first_rd), 32'd0);
    chk("t1_latency",   32'(first_v), 32'(first_rd + 1));
    chk("t1_n",         32'(xfer_n), 32'd8);
    chk("t1_back2back", 32'(xfer_last - xfer_first), 32'd7);
    chk("t1_left",      32'(exp_q.size()), 32'd0);
    chk("t1_beats",     32'(beat_cnt), 32'd8);
    chk("t1_ptr",       32'(rd_ptr), 32'd0);
    chk("t1_err",       32'(order_err), 32'd0);

    // Backpressure: only two pops while stalled, head held
    clr_trk();
    for (int b = 0; b < 4; b++) begin
      bq[b].push_back(8'(8'h50 + b));
      exp_q.push_back(8'(8'h50 + b));
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t2_pops",  32'(npop), 32'd2);
    chk("t2_head",  32'(bus.out_data), 32'h50);
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("t2_n",     32'(xfer_n), 32'd4);
    chk("t2_left",  32'(exp_q.size()), 32'd0);
    chk("t2_beats", 32'(beat_cnt), 32'd12);

    // Pointer wrap with one write per cycle
    do_reset();
    clr_trk();
    for (int i = 0; i < 10; i++) begin
      bq[i % 4].push_back(8'(i));
      exp_q.push_back(8'(i));
      tick();
    end
    for (int k = 0; k < 5; k++) tick();
    chk("t3_left",  32'(exp_q.size()), 32'd0);
    chk("t3_beats", 32'(beat_cnt), 32'd10);
    chk("t3_ptr",   32'(rd_ptr), 32'd2);

    // Stall then skip of bank 0
    do_reset();
    clr_trk();
    for (int b = 1; b < 4; b++) begin
      bq[b].push_back(8'(8'hA0 + b));
      exp_q.push_back(8'(8'hA0 + b));
    end
    for (int k = 0; k < 17; k++) tick();
    chk("t4_no_pop",  32'(first_rd), 32'hFFFF_FFFF);
    chk("t4_ptr_skp", 32'(rd_ptr), 32'd1);
    chk("t4_err",     32'(order_err), 32'd1);
    chk("t4_skip",    32'(skip_cnt), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    chk("t4_first_rd", 32'(first_rd), 32'd17);
    chk("t4_first_v",  32'(first_v), 32'd18);
    chk("t4_left",     32'(exp_q.size()), 32'd0);
    chk("t4_ptr",      32'(rd_ptr), 32'd0);
    chk("t4_skip_end", 32'(skip_cnt), 32'd1);

    // All banks empty is not a stall
    do_reset();
    clr_trk();
    for (int k = 0; k < 100; k++) tick();
    chk("t5_skip",  32'(skip_cnt), 32'd0);
    chk("t5_err",   32'(order_err), 32'd0);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_ptr",   32'(rd_ptr), 32'd0);

    // Reset with two beats buffered, then reset with a non-empty bank
    clr_trk();
    bq[0].push_back(8'hB0); bq[1].push_back(8'hB1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_valid_pre", 32'(bus.out_valid), 32'd1);
    chk("t6_head_pre",  32'(bus.out_data), 32'hB0);
    do_reset();
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_beats", 32'(beat_cnt), 32'd0);
    chk("t6_ptr",   32'(rd_ptr), 32'd0);
    chk("t6_skip",  32'(skip_cnt), 32'd0);
    bq[0].push_back(8'hC0);
    do_reset();
    chk("t6_no_pop_rst", 32'(bq[0].size()), 32'd1);
    exp_q.push_back(8'hC0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_left",  32'(exp_q.size()), 32'd0);
    chk("t6_beats_end", 32'(beat_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
